// File: rtl/temp_bcd_pkg.sv
// Shared definitions for the sequential fixed-point to BCD converter:
// FSM state encoding, BCD digit constants and a constant-function clog2.
package temp_bcd_pkg;

  localparam int BCD_W      = 4;
  localparam int DABBLE_ADJ = 3;
  localparam int DABBLE_THR = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INT   = 3'd1,
    ST_FRAC  = 3'd2,
    ST_ROUND = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Smallest r with 2**r >= v (returns 0 for v <= 1).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_dabble_cell.sv
// One BCD digit of the double-dabble chain: add 3 when the digit is >= 5,
// then shift left by one, taking the incoming bit at the LSB and handing
// the outgoing MSB to the next more significant digit.
module bcd_dabble_cell
  import temp_bcd_pkg::*;
(
  input  logic [BCD_W-1:0] i_digit,
  input  logic             i_carry,
  output logic [BCD_W-1:0] o_digit,
  output logic             o_carry
);

  logic [BCD_W-1:0] w_adj;

  // Conditional +3 so the following shift carries correctly into the next decade.
  always_comb begin
    w_adj = i_digit;
    if (i_digit >= BCD_W'(DABBLE_THR)) w_adj = i_digit + BCD_W'(DABBLE_ADJ);
  end

  assign o_digit = {w_adj[BCD_W-2:0], i_carry};
  assign o_carry = w_adj[BCD_W-1];

endmodule

// File: rtl/temp_fix2bcd_seq.sv
// Sequential fixed-point temperature to packed BCD converter.
// Integer field: iterative double-dabble, one input bit per cycle.
// Fraction field: exact iterative multiply-by-10, one digit per cycle.
// Optional build macro TEMP_BCD_ROUND_EN adds a ROUND state that derives a
// guard digit and rounds half-up, saturating to all nines on overflow.
//
// Handshakes: a word transfers on a rising edge where valid && ready are both
// high. in_ready is high only in IDLE. out_valid, int_bcd and frac_bcd are
// registered and stay constant from out_valid rising until the edge where
// out_ready is also high; out_ready is ignored while out_valid is low.
module temp_fix2bcd_seq
  import temp_bcd_pkg::*;
#(
  parameter int INT_W       = 7,
  parameter int FRAC_W      = 8,
  parameter int INT_DIGITS  = 3,
  parameter int FRAC_DIGITS = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [INT_W+FRAC_W-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [4*INT_DIGITS-1:0]   int_bcd,
  output logic [4*FRAC_DIGITS-1:0]  frac_bcd,
  output logic                      busy,
  output state_t                    dbg_state
);

  localparam int DW      = INT_W + FRAC_W;
  localparam int IB      = BCD_W * INT_DIGITS;
  localparam int FB      = BCD_W * FRAC_DIGITS;
  localparam int CNT_MAX = (INT_W > FRAC_DIGITS) ? INT_W : FRAC_DIGITS;
  localparam int CNT_W   = clog2(CNT_MAX + 1);

  state_t            r_state;
  state_t            w_next;
  logic [INT_W-1:0]  r_shift;
  logic [IB-1:0]     r_int_acc;
  logic [FRAC_W-1:0] r_frac_reg;
  logic [FB-1:0]     r_frac_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [IB-1:0]     r_int_out;
  logic [FB-1:0]     r_frac_out;
  logic              r_out_valid;

  logic [INT_DIGITS:0] w_carry;
  logic [IB-1:0]       w_int_dab;
  logic [IB-1:0]       w_int_next;
  logic [FRAC_W+3:0]   w_p;
  logic [BCD_W-1:0]    w_digit;

  // Double-dabble chain across all integer digits.
  assign w_carry[0] = r_shift[INT_W-1];
  for (genvar g = 0; g < INT_DIGITS; g++) begin : g_dabble
    bcd_dabble_cell u_cell (
      .i_digit (r_int_acc[BCD_W*g +: BCD_W]),
      .i_carry (w_carry[g]),
      .o_digit (w_int_dab[BCD_W*g +: BCD_W]),
      .o_carry (w_carry[g+1])
    );
  end

  // A carry out of the top digit cannot occur for legal parameters; clamp anyway.
  assign w_int_next = w_carry[INT_DIGITS] ? {INT_DIGITS{4'd9}} : w_int_dab;

  // Fraction times ten; the top nibble is the next decimal digit.
  assign w_p     = ({4'b0, r_frac_reg} << 3) + ({4'b0, r_frac_reg} << 1);
  assign w_digit = w_p[FRAC_W+3:FRAC_W];

`ifdef TEMP_BCD_ROUND_EN
  logic [IB-1:0] w_rnd_int;
  logic [FB-1:0] w_rnd_frac;
  logic          w_rnd_carry;

  // Half-up rounding from the guard digit with decimal carry ripple.
  always_comb begin
    w_rnd_int   = r_int_acc;
    w_rnd_frac  = r_frac_acc;
    w_rnd_carry = (w_digit >= 4'd5);
    for (int k = 0; k < FRAC_DIGITS; k++) begin
      if (w_rnd_carry) begin
        if (w_rnd_frac[BCD_W*k +: BCD_W] == 4'd9) begin
          w_rnd_frac[BCD_W*k +: BCD_W] = 4'd0;
        end else begin
          w_rnd_frac[BCD_W*k +: BCD_W] = w_rnd_frac[BCD_W*k +: BCD_W] + 4'd1;
          w_rnd_carry = 1'b0;
        end
      end
    end
    for (int k = 0; k < INT_DIGITS; k++) begin
      if (w_rnd_carry) begin
        if (w_rnd_int[BCD_W*k +: BCD_W] == 4'd9) begin
          w_rnd_int[BCD_W*k +: BCD_W] = 4'd0;
        end else begin
          w_rnd_int[BCD_W*k +: BCD_W] = w_rnd_int[BCD_W*k +: BCD_W] + 4'd1;
          w_rnd_carry = 1'b0;
        end
      end
    end
    if (w_rnd_carry) begin
      w_rnd_int  = {INT_DIGITS{4'd9}};
      w_rnd_frac = {FRAC_DIGITS{4'd9}};
    end
  end
`endif

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (in_valid) w_next = ST_INT;
      ST_INT:   if (r_cnt == CNT_W'(INT_W - 1)) w_next = ST_FRAC;
      ST_FRAC: begin
        if (r_cnt == CNT_W'(FRAC_DIGITS - 1)) begin
`ifdef TEMP_BCD_ROUND_EN
          w_next = ST_ROUND;
`else
          w_next = ST_DONE;
`endif
        end
      end
      ST_ROUND: w_next = ST_DONE;
      ST_DONE:  if (r_out_valid && out_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Datapath: load, dabble, multiply-by-10, optional round, output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift     <= '0;
      r_int_acc   <= '0;
      r_frac_reg  <= '0;
      r_frac_acc  <= '0;
      r_cnt       <= '0;
      r_int_out   <= '0;
      r_frac_out  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_shift    <= in_data[DW-1:FRAC_W];
            r_frac_reg <= in_data[FRAC_W-1:0];
            r_int_acc  <= '0;
            r_frac_acc <= '0;
            r_cnt      <= '0;
          end
        end
        ST_INT: begin
          r_int_acc <= w_int_next;
          r_shift   <= r_shift << 1;
          r_cnt     <= (r_cnt == CNT_W'(INT_W - 1)) ? '0 : r_cnt + 1'b1;
        end
        ST_FRAC: begin
          r_frac_acc <= (r_frac_acc << BCD_W) | FB'(w_digit);
          r_frac_reg <= w_p[FRAC_W-1:0];
          r_cnt      <= (r_cnt == CNT_W'(FRAC_DIGITS - 1)) ? '0 : r_cnt + 1'b1;
        end
`ifdef TEMP_BCD_ROUND_EN
        ST_ROUND: begin
          r_int_acc  <= w_rnd_int;
          r_frac_acc <= w_rnd_frac;
        end
`endif
        ST_DONE: begin
          if (!r_out_valid) begin
            r_int_out   <= r_int_acc;
            r_frac_out  <= r_frac_acc;
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign out_valid = r_out_valid;
  assign int_bcd   = r_int_out;
  assign frac_bcd  = r_frac_out;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_temp_fix2bcd_seq.sv
// Bench for temp_fix2bcd_seq at default parameters. Build with
// TEMP_BCD_ROUND_EN defined to exercise the rounding variant.
module tb_temp_fix2bcd_seq;
  import temp_bcd_pkg::*;

  localparam int INT_W       = 7;
  localparam int FRAC_W      = 8;
  localparam int INT_DIGITS  = 3;
  localparam int FRAC_DIGITS = 2;
  localparam int DW          = INT_W + FRAC_W;
  localparam int IB          = 4 * INT_DIGITS;
  localparam int FB          = 4 * FRAC_DIGITS;
`ifdef TEMP_BCD_ROUND_EN
  localparam int LAT = 11;
`else
  localparam int LAT = 10;
`endif

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [IB-1:0] int_bcd;
  logic [FB-1:0] frac_bcd;
  logic          busy;
  state_t        dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [IB+FB-1:0] exp_q[$];

  temp_fix2bcd_seq #(
    .INT_W(INT_W), .FRAC_W(FRAC_W), .INT_DIGITS(INT_DIGITS), .FRAC_DIGITS(FRAC_DIGITS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .int_bcd(int_bcd), .frac_bcd(frac_bcd), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: decimal value computed with plain integer arithmetic,
  // then split into packed BCD digits.
  function automatic logic [IB+FB-1:0] model(input logic [DW-1:0] d);
    longint ip, fp, scale, t, v, lim;
    logic [IB+FB-1:0] r;
    ip = longint'(d) >> FRAC_W;
    fp = longint'(d) & ((longint'(1) << FRAC_W) - 1);
    scale = 1;
    for (int i = 0; i < FRAC_DIGITS; i++) scale = scale * 10;
    lim = scale;
    for (int i = 0; i < INT_DIGITS; i++) lim = lim * 10;
`ifdef TEMP_BCD_ROUND_EN
    t = (fp * scale * 10) >> FRAC_W;
    v = ip * scale + t / 10 + (((t % 10) >= 5) ? 1 : 0);
    if (v >= lim) v = lim - 1;
`else
    v = ip * scale + ((fp * scale) >> FRAC_W);
`endif
    r = '0;
    for (int k = 0; k < INT_DIGITS + FRAC_DIGITS; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Scoreboard: push on input accept, compare every cycle out_valid is high.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_out", 32'd1, 32'd0);
        end else begin
          chk("sb_int", 32'(int_bcd), 32'(exp_q[0][IB+FB-1:FB]));
          chk("sb_frac", 32'(frac_bcd), 32'(exp_q[0][FB-1:0]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      chk("sb_ready_excl", 32'(in_ready & (busy | out_valid)), 32'd0);
      if (in_valid && in_ready) exp_q.push_back(model(in_data));
    end
  end

  // Driver tasks
  task automatic wait_ready();
    int k;
    k = 0;
    while (!in_ready && k < 64) begin
      @(posedge clk); #1;
      k++;
    end
    if (!in_ready) chk("timeout_in_ready", 32'd0, 32'd1);
  endtask

  task automatic send(input logic [DW-1:0] d);
    wait_ready();
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) chk("timeout_out_valid", 32'd0, 32'd1);
  endtask

  task automatic take(input logic [IB-1:0] ei, input logic [FB-1:0] ef, input string nm);
    chk({nm, "_int"}, 32'(int_bcd), 32'(ei));
    chk({nm, "_frac"}, 32'(frac_bcd), 32'(ef));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic convert(input logic [DW-1:0] d, input logic [IB-1:0] ei,
                         input logic [FB-1:0] ef, input string nm);
    int lat;
    send(d);
    wait_valid(lat);
    chk({nm, "_latency"}, 32'(lat), 32'(LAT));
    take(ei, ef, nm);
  endtask

  initial begin
    int lat;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_int", 32'(int_bcd), 32'd0);
    chk("rst_frac", 32'(frac_bcd), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors with hand-computed digits
    convert(15'h2540, 12'h037, 8'h25, "v37_25");
`ifdef TEMP_BCD_ROUND_EN
    convert(15'h24E6, 12'h036, 8'h90, "v36_898");
    convert(15'h7FFF, 12'h128, 8'h00, "vmax");
    convert(15'h00FF, 12'h001, 8'h00, "v0_996");
`else
    convert(15'h24E6, 12'h036, 8'h89, "v36_898");
    convert(15'h7FFF, 12'h127, 8'h99, "vmax");
    convert(15'h00FF, 12'h000, 8'h99, "v0_996");
`endif
    convert(15'h0000, 12'h000, 8'h00, "vzero");
    convert(15'h7F80, 12'h127, 8'h50, "v127_5");
    convert(15'h0001, 12'h000, 8'h00, "vlsb");
    convert(15'h0A1A, 12'h010, 8'h10, "v10_10");

    // Back-pressure: result held, new words ignored while out_ready is low
    send(15'h2540);
    wait_valid(lat);
    for (int k = 0; k < 20; k++) begin
      in_valid = k[0];
      in_data  = 15'h1111;
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_int", 32'(int_bcd), 32'h037);
      chk("bp_frac", 32'(frac_bcd), 32'h25);
    end
    in_valid  = 1'b1;
    in_data   = 15'h2580;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    chk("bp_release_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_accept_busy", 32'(busy), 32'd1);
    wait_valid(lat);
    take(12'h037, 8'h50, "bp_next");

    // Asynchronous reset in the middle of INT
    send(15'h7FFF);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_int", 32'(int_bcd), 32'd0);
    chk("mid_rst_frac", 32'(frac_bcd), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    convert(15'h0000, 12'h000, 8'h00, "after_rst");

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
